logic_bram_unsum: RTL and testbench
===================================

LOGIC_BRAM_UNSUM -- requirements
Module: logic_bram_unsum

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of the completed-transaction counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream operand pair valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts operand pair this cycle.
REQ-007 SHALL have port in_res, input, WIDTH, registered sum previously produced as A+B+1.
REQ-008 SHALL have port in_b, input, WIDTH, known addend B.
REQ-009 SHALL have port out_valid, output, 1, recovered operand valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port out_a, output, WIDTH, recovered operand A.
REQ-012 SHALL have port out_borrow, output, 1, unsigned underflow flag (present only with the REQ-024 macro).
REQ-013 SHALL have port done_cnt, output, CNT_W, count of results accepted downstream.

Function
REQ-014 SHALL compute out_a = (in_res - in_b - 1) mod 2^WIDTH, the inverse of A+B+1.
REQ-015 SHALL be a 2-stage pipeline: S1 registers in_res/in_b, S2 registers the difference; latency 2 cycles from in_valid&&in_ready to out_valid with no stall.
REQ-016 SHALL transfer on input when in_valid&&in_ready, and on output when out_valid&&out_ready.
REQ-017 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready (combinational, no dependency on in_valid).
REQ-018 SHALL advance S1 into S2 when s1_valid && (!s2_valid || out_ready).
REQ-019 SHALL hold out_a, out_borrow and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-021 SHALL, on a simultaneous input accept and output accept in the same cycle, perform both with no loss or duplication.
REQ-022 SHALL increment done_cnt by 1 per output transfer, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-023 SHALL, on rst_n low (asynchronous, at any time including mid-stream), clear s1_valid, out_valid, out_a, out_borrow and done_cnt to 0 and discard in-flight data; in_ready SHALL be 1 while reset is held low and after reset releases.

Configuration
REQ-024 SHALL compile out_borrow logic only when macro LOGIC_BRAM_UNSUM_BORROW_EN is defined: out_borrow = 1 when in_res < in_b + 1 (evaluated in WIDTH+1 bits), registered alongside out_a.
REQ-025 SHALL, without LOGIC_BRAM_UNSUM_BORROW_EN, omit the out_borrow port entirely; all other behaviour is unchanged.

Structure
REQ-026 SHALL place the default WIDTH/CNT_W constants and the unsum difference function in shared package logic_bram_pkg.
REQ-027 SHALL implement each pipeline stage with one sub-module, unsum_pipe_stage (valid/data register with load enable and async active-low clear), instantiated twice.

Verification
REQ-028 SHALL check basic: in_res=4'h5, in_b=4'h2 -> out_a=4'h2, out_borrow=0, out_valid exactly 2 cycles after accept.
REQ-029 SHALL check wrap: in_res=4'h0, in_b=4'h0 -> out_a=4'hF, out_borrow=1 (macro on); in_res=4'h3, in_b=4'hF -> out_a=4'h3, out_borrow=1.
REQ-030 SHALL check backpressure: stream 4 pairs with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, out_a held constant, then all 4 results delivered in order with no loss.
REQ-031 SHALL check throughput: 20 back-to-back pairs with out_ready=1 -> 20 results on 20 consecutive cycles, done_cnt=20.
REQ-032 SHALL check counter wrap: 256 output transfers with CNT_W=8 -> done_cnt=0.
REQ-033 SHALL check reset mid-operation: assert rst_n=0 with both stages full -> out_valid=0, done_cnt=0 immediately; no stale result emitted after release.

Source files
------------

// File: rtl/logic_bram_pkg.sv
// Shared constants and the unsum difference helper for logic_bram_unsum.
// The helper inverts a registered A+B+1 sum; the borrow lands in the top bit.
package logic_bram_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_W     = 32;

    // Callers zero-extend to MAX_W+1 bits, so a negative result sets bit MAX_W.
    function automatic logic [MAX_W:0] unsum_diff(
        input logic [MAX_W:0] res,
        input logic [MAX_W:0] b
    );
        return res - b - (MAX_W+1)'(1);
    endfunction

endpackage

// File: rtl/unsum_pipe_stage.sv
// One pipeline slot: valid flag plus data word, load has priority over unload.
// Both valid and data clear asynchronously on rst_n low.
module unsum_pipe_stage
    import logic_bram_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          unload,
    input  logic [DW-1:0] d,
    output logic          valid,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_bram_unsum.sv
// Two-stage valid/ready pipeline recovering A from a registered A+B+1 sum.
// Optional out_borrow port is built only with LOGIC_BRAM_UNSUM_BORROW_EN.
module logic_bram_unsum
    import logic_bram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_res,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
`ifdef LOGIC_BRAM_UNSUM_BORROW_EN
    output logic             out_borrow,
`endif
    output logic [CNT_W-1:0] done_cnt
);

    localparam int S1W = 2 * WIDTH;
`ifdef LOGIC_BRAM_UNSUM_BORROW_EN
    localparam int S2W = WIDTH + 1;
`else
    localparam int S2W = WIDTH;
`endif

    logic             s1_valid;
    logic             s2_valid;
    logic             in_fire;
    logic             adv;
    logic             out_fire;
    logic [S1W-1:0]   s1_q;
    logic [WIDTH-1:0] s1_res;
    logic [WIDTH-1:0] s1_b;
    logic [S2W-1:0]   s2_d;
    logic [S2W-1:0]   s2_q;

    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign adv      = s1_valid && (!s2_valid || out_ready);
    assign out_fire = s2_valid && out_ready;

    assign {s1_res, s1_b} = s1_q;

    // With borrow enabled the extra bit kept is the sign of res-b-1.
    assign s2_d = S2W'(unsum_diff((MAX_W+1)'(s1_res),
                                  (MAX_W+1)'(s1_b)));

    unsum_pipe_stage #(.DW(S1W)) u_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (in_fire),
        .unload (adv),
        .d      ({in_res, in_b}),
        .valid  (s1_valid),
        .q      (s1_q)
    );

    unsum_pipe_stage #(.DW(S2W)) u_s2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (adv),
        .unload (out_fire),
        .d      (s2_d),
        .valid  (s2_valid),
        .q      (s2_q)
    );

    assign out_valid = s2_valid;
    assign out_a     = s2_q[WIDTH-1:0];
`ifdef LOGIC_BRAM_UNSUM_BORROW_EN
    assign out_borrow = s2_q[WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_fire) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_bram_unsum.sv
// Bench for logic_bram_unsum: queue-based reference model checked every cycle
// plus directed vectors with hand-computed literals.
module tb_logic_bram_unsum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_res = '0;
    logic [3:0] in_b = '0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_a;
    logic [7:0] done_cnt;
`ifdef LOGIC_BRAM_UNSUM_BORROW_EN
    logic       out_borrow;
`endif

    logic_bram_unsum #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
`ifdef LOGIC_BRAM_UNSUM_BORROW_EN
        .out_borrow(out_borrow),
`endif
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] a;
        logic       bw;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         cyc = 0;
    logic [7:0] cnt_m = '0;
    logic       exp_v;
    logic       exp_r;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Reference model: items live in a FIFO; head becomes visible 2 cycles
    // after acceptance, and at most 2 items may be in flight.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = '0;
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_cnt", 32'(done_cnt), 32'd0);
            chk("rst_ready", 32'(in_ready), 32'd1);
        end else begin
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = (cyc - q[0].cyc) >= 2;
            exp_r = (q.size() < 2) || out_ready;
            chk("m_ready", 32'(in_ready), 32'(exp_r));
            chk("m_valid", 32'(out_valid), 32'(exp_v));
            chk("m_cnt", 32'(done_cnt), 32'(cnt_m));
            if (exp_v) begin
                chk("m_a", 32'(out_a), 32'(q[0].a));
`ifdef LOGIC_BRAM_UNSUM_BORROW_EN
                chk("m_borrow", 32'(out_borrow), 32'(q[0].bw));
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    cnt_m = cnt_m + 8'd1;
                end
            end
            if (in_valid && exp_r) begin
                e.a   = 4'(int'(in_res) - int'(in_b) - 1);
                e.bw  = int'(in_res) < (int'(in_b) + 1);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic send_one(input logic [3:0] r, input logic [3:0] b,
                            input logic [3:0] ea, input logic eb);
        in_res = r;
        in_b = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_v1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_v2", 32'(out_valid), 32'd1);
        chk("lit_a", 32'(out_a), 32'(ea));
`ifdef LOGIC_BRAM_UNSUM_BORROW_EN
        chk("lit_borrow", 32'(out_borrow), 32'(eb));
`else
        if (eb !== 1'bx) begin end
`endif
        tick();
        chk("drain_v", 32'(out_valid), 32'd0);
    endtask

    int consec;

    initial begin
        tick();
        chk("init_valid", 32'(out_valid), 32'd0);
        chk("init_ready", 32'(in_ready), 32'd1);
        chk("init_cnt", 32'(done_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        send_one(4'h5, 4'h2, 4'h2, 1'b0);
        send_one(4'h0, 4'h0, 4'hF, 1'b1);
        send_one(4'h3, 4'hF, 4'h3, 1'b1);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_res = 4'h9; in_b = 4'h4;
        tick();
        in_res = 4'h1; in_b = 4'h7;
        tick();
        in_res = 4'hC; in_b = 4'h3;
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_a0", 32'(out_a), 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_a", 32'(out_a), 32'h4);
            chk("bp_hold_r", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_res = 4'h0; in_b = 4'h1;
        chk("bp_a1", 32'(out_a), 32'h9);
        tick();
        in_valid = 1'b0;
        chk("bp_a2", 32'(out_a), 32'h8);
        tick();
        chk("bp_a3", 32'(out_a), 32'hE);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_cnt", 32'(done_cnt), 32'd4);

        // reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_res = 4'h5; in_b = 4'h2;
        tick();
        in_res = 4'h6; in_b = 4'h1;
        tick();
        in_valid = 1'b0;
        chk("rm_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_cnt", 32'(done_cnt), 32'd0);
        chk("rm_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rm_stale", 32'(out_valid), 32'd0);
        end

        // throughput
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_res = 4'h0; in_b = 4'h0;
        consec = 0;
        for (int k = 0; k < 22; k++) begin
            tick();
            if (k < 19) begin
                in_res = 4'((k + 1) * 3);
                in_b = 4'(k + 1);
            end else begin
                in_valid = 1'b0;
            end
            if (k >= 1 && k <= 20 && out_valid) consec++;
        end
        chk("tp_consec", 32'(consec), 32'd20);
        chk("tp_cnt", 32'(done_cnt), 32'd20);

        // counter wrap
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_res = 4'(i * 7);
            in_b = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_cnt", 32'(done_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

endmodule
